// File: rtl/i2s_adc_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_adc_rx
// Brief    : I2S ADC capture deserializer; emits left/right sample pairs on a
//            valid/ready interface, all in the clk_50m domain.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_adc_rx #(
  parameter int DEPTH = 16
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             p_bclk,
  input  logic             adc_lrc,
  input  logic             adcdat,
  output logic [DEPTH-1:0] left_data,
  output logic [DEPTH-1:0] right_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    CAP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic              chan, chan_nx;   // 0 = left, 1 = right
  logic              r_adc_meta, r_adc_sync;
  logic              lrc_q;
  logic [CW-1:0]     bit_cnt;
  logic [DEPTH-1:0]  shreg;
  logic [DEPTH-1:0]  left_hold;

  logic              w_boundary;
  logic              w_full;
  logic              w_last_bit;
  logic [DEPTH-1:0]  w_shift_word;
  logic              w_cnt_clr;
  logic              w_do_shift;
  logic              w_load_left;
  logic              w_clr_left;
  logic              w_pair_done;
  logic              w_set_ferr;
  logic              w_accept;

  assign w_boundary   = p_bclk && (adc_lrc != lrc_q);
  assign w_full       = (bit_cnt == CW'(DEPTH));
  assign w_last_bit   = (bit_cnt == CW'(DEPTH - 1));
  assign w_shift_word = {shreg[DEPTH-2:0], r_adc_sync};
  assign w_accept     = out_valid && out_ready;

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state <= SYNC;
      chan  <= 1'b0;
    end else begin
      state <= state_nx;
      chan  <= chan_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    chan_nx     = chan;
    w_cnt_clr   = 1'b0;
    w_do_shift  = 1'b0;
    w_load_left = 1'b0;
    w_clr_left  = 1'b0;
    w_pair_done = 1'b0;
    w_set_ferr  = 1'b0;
    case (state)
      SYNC: begin
        if (w_boundary && !adc_lrc) begin
          state_nx  = CAP;
          chan_nx   = 1'b0;
          w_cnt_clr = 1'b1;
        end
      end
      CAP: begin
        if (w_boundary) begin
          // The boundary strobe is the one-bit delay slot; its data is ignored.
          w_cnt_clr  = 1'b1;
          w_set_ferr = !w_full;
          if (!adc_lrc) begin
            chan_nx = 1'b0;
          end else if (w_full) begin
            chan_nx = 1'b1;
          end else begin
            state_nx   = SYNC;
            w_clr_left = 1'b1;
          end
        end else if (p_bclk && !w_full) begin
          w_do_shift = 1'b1;
          if (w_last_bit) begin
            if (!chan) begin
              w_load_left = 1'b1;
            end else begin
              w_pair_done = 1'b1;
              state_nx    = DONE;
            end
          end
        end
      end
      DONE: begin
        if (w_boundary) begin
          state_nx  = CAP;
          chan_nx   = adc_lrc;
          w_cnt_clr = 1'b1;
        end
      end
      default: begin
        state_nx = SYNC;
        chan_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      r_adc_meta <= 1'b0;
      r_adc_sync <= 1'b0;
      lrc_q      <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      left_hold  <= '0;
      left_data  <= '0;
      right_data <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_adc_meta <= adcdat;
      r_adc_sync <= r_adc_meta;

      if (p_bclk) begin
        lrc_q <= adc_lrc;
      end

      if (w_cnt_clr) begin
        bit_cnt <= '0;
      end else if (w_do_shift) begin
        bit_cnt <= bit_cnt + CW'(1);
      end

      if (w_do_shift) begin
        shreg <= w_shift_word;
      end

      if (w_load_left) begin
        left_hold <= w_shift_word;
      end else if (w_clr_left) begin
        left_hold <= '0;
      end

      if (w_set_ferr) begin
        frame_err <= 1'b1;
      end

      // A completing pair may load in the same cycle the old one is accepted.
      if (w_pair_done) begin
        if (!out_valid || out_ready) begin
          left_data  <= left_hold;
          right_data <= w_shift_word;
          out_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (w_accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_adc_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_adc_rx
// Brief    : Scoreboard bench for i2s_adc_rx driving directed I2S frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_adc_rx;

  localparam int DEPTH     = 16;
  localparam int SLOT_PER  = DEPTH + 3;
  localparam int HALF_BCLK = 8;

  logic             clk_50m = 1'b0;
  logic             rst_n;
  logic             p_bclk;
  logic             adc_lrc;
  logic             adcdat;
  logic [DEPTH-1:0] left_data;
  logic [DEPTH-1:0] right_data;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             frame_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*DEPTH-1:0] exp_q[$];

  i2s_adc_rx #(.DEPTH(DEPTH)) dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .p_bclk     (p_bclk),
    .adc_lrc    (adc_lrc),
    .adcdat     (adcdat),
    .left_data  (left_data),
    .right_data (right_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every accepted handshake must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk_50m);
      #1;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pair", {left_data, right_data}, 32'h0);
        end else begin
          check("pair", {left_data, right_data}, exp_q.pop_front());
        end
      end
    end
  end

  // One BCLK period entered and left on a clk negedge; lrc/data change at the
  // falling edge, the rising-edge strobe follows half a period later.
  task automatic bclk_period(input logic lrc, input logic d, input logic raise);
    adc_lrc = lrc;
    adcdat  = d;
    repeat (HALF_BCLK) @(negedge clk_50m);
    p_bclk = 1'b1;
    if (raise) out_ready = 1'b1;
    @(negedge clk_50m);
    p_bclk = 1'b0;
    repeat (HALF_BCLK - 1) @(negedge clk_50m);
  endtask

  task automatic send_slot(input logic lrc, input logic [DEPTH-1:0] w,
                           input int first, input int nper, input logic raise);
    for (int k = first; k < nper; k++) begin
      logic d;
      d = (k >= 1 && k <= DEPTH) ? w[DEPTH-k] : 1'($urandom);
      bclk_period(lrc, d, raise && (k == DEPTH));
    end
  endtask

  task automatic send_frame(input logic [DEPTH-1:0] l, input logic [DEPTH-1:0] r,
                            input logic raise);
    send_slot(1'b0, l, 0, SLOT_PER, 1'b0);
    send_slot(1'b1, r, 0, SLOT_PER, raise);
  endtask

  initial begin
    #(20 * 90000);
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DEPTH-1:0] l, r;
    rst_n = 1'b0; p_bclk = 1'b0; adc_lrc = 1'b0; adcdat = 1'b0; out_ready = 1'b0;

    // Reset with random stimulus
    repeat (4) begin
      @(negedge clk_50m);
      p_bclk = 1'($urandom); adc_lrc = 1'($urandom);
      adcdat = 1'($urandom); out_ready = 1'($urandom);
    end
    @(negedge clk_50m);
    check("rst_left",      32'(left_data),  32'h0);
    check("rst_right",     32'(right_data), 32'h0);
    check("rst_valid",     32'(out_valid),  32'h0);
    check("rst_overrun",   32'(overrun),    32'h0);
    check("rst_frame_err", 32'(frame_err),  32'h0);

    // Release reset partway through a right slot carrying FFFF
    p_bclk = 1'b0; out_ready = 1'b1;
    send_slot(1'b1, 16'hFFFF, 0, 5, 1'b0);
    rst_n = 1'b1;
    send_slot(1'b1, 16'hFFFF, 5, SLOT_PER, 1'b0);
    check("midstart_no_valid", 32'(out_valid), 32'h0);

    // Normal frame
    exp_q.push_back({16'hA5C3, 16'h1234});
    send_frame(16'hA5C3, 16'h1234, 1'b0);
    check("normal_valid_pulse", 32'(out_valid), 32'h0);
    check("normal_overrun",     32'(overrun),   32'h0);
    check("normal_frame_err",   32'(frame_err), 32'h0);

    // Random frames
    for (int i = 0; i < 8; i++) begin
      l = DEPTH'($urandom); r = DEPTH'($urandom);
      exp_q.push_back({l, r});
      send_frame(l, r, 1'b0);
    end

    // Accept the held pair in the very cycle the next pair completes
    out_ready = 1'b0;
    exp_q.push_back({16'h0F0F, 16'hF0F0});
    send_frame(16'h0F0F, 16'hF0F0, 1'b0);
    check("simul_held", 32'(out_valid), 32'h1);
    exp_q.push_back({16'h8001, 16'h7FFE});
    send_frame(16'h8001, 16'h7FFE, 1'b1);
    check("simul_overrun", 32'(overrun), 32'h0);
    check("simul_drained", 32'(exp_q.size()), 32'h0);

    // Short left slot: lrc toggles after 10 bits
    send_slot(1'b0, 16'hDEAD, 0, 11, 1'b0);
    send_slot(1'b1, 16'hBEEF, 0, SLOT_PER, 1'b0);
    check("short_frame_err", 32'(frame_err), 32'h1);
    check("short_no_pair",   32'(exp_q.size()), 32'h0);
    exp_q.push_back({16'h1357, 16'h2468});
    send_frame(16'h1357, 16'h2468, 1'b0);

    // Backpressure across two frames
    out_ready = 1'b0;
    exp_q.push_back({16'hCAFE, 16'hBABE});
    send_frame(16'hCAFE, 16'hBABE, 1'b0);
    send_frame(16'h5555, 16'hAAAA, 1'b0);
    check("bp_overrun", 32'(overrun),    32'h1);
    check("bp_valid",   32'(out_valid),  32'h1);
    check("bp_left",    32'(left_data),  32'hCAFE);
    out_ready = 1'b1;
    repeat (4) @(negedge clk_50m);
    exp_q.push_back({16'h3C3C, 16'hC3C3});
    send_frame(16'h3C3C, 16'hC3C3, 1'b0);

    repeat (20) @(negedge clk_50m);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_adc_rx.md
# i2s_adc_rx

I2S capture deserializer for the codec ADC path. It consumes the bit-clock strobes and ADC_LRC from the codec timing generator, samples the serial ADCDAT line, and presents aligned left/right sample pairs on a valid/ready interface to the downstream analysis pipeline. It runs entirely in the clk_50m domain; BCLK itself is never used as a clock.

## Interface
- DEPTH, 16, sample width in bits, MSB first.
- clk_50m  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, synchronous, active-low.
- p_bclk  in  1  one-cycle strobe marking each BCLK rising edge.
- adc_lrc  in  1  ADC_LRC level: 0 = left slot, 1 = right slot. Changes only at BCLK falling edges.
- adcdat  in  1  serial data from the codec, asynchronous to clk_50m.
- left_data  out  DEPTH  captured left sample.
- right_data  out  DEPTH  captured right sample.
- out_valid  out  1  sample pair available; held until accepted.
- out_ready  in  1  consumer accepts the pair when out_valid && out_ready.
- overrun  out  1  sticky: a completed pair was dropped because out_valid was still pending.
- frame_err  out  1  sticky: a slot ended before DEPTH bits were captured.

## Operation
- adcdat passes through a 2-FF synchronizer. All sampling uses the synchronizer output.
- adc_lrc is sampled only on p_bclk into lrc_q. A slot boundary is a p_bclk where adc_lrc != lrc_q.
- The boundary p_bclk is the I2S one-bit delay slot. Its data bit is ignored.
- The next DEPTH p_bclk strobes shift data into shreg (left shift, MSB first).
- bit_cnt has width $clog2(DEPTH+1) and saturates at DEPTH. Once it reaches DEPTH, further bits in the slot are ignored.
- State machine:
  - SYNC (reset state): wait for a boundary with adc_lrc == 0 (left slot start), then go to CAP with chan = L and bit_cnt = 0.
  - CAP: shift on each non-boundary p_bclk. When bit_cnt reaches DEPTH:
    - chan = L: load left_hold.
    - chan = R: complete the pair. Go to DONE.
  - CAP, boundary while bit_cnt < DEPTH: set frame_err and discard the partial word.
    - New slot is left: restart CAP with chan = L.
    - New slot is right: discard left_hold and go to SYNC. No pair is emitted for that frame.
  - DONE: ignore bits until a boundary.
    - Boundary to left: go to CAP with chan = L.
    - Boundary to right: go to CAP with chan = R. This is the normal left-to-right transition; the left word is already complete.
- Pair completion:
  - out_valid = 0, or out_valid && out_ready in the same cycle: load left_data = left_hold and right_data = shreg, and set out_valid = 1.
  - Otherwise: drop the new pair, keep the old data, and set overrun.
- Acceptance: when out_valid && out_ready and no new pair completes in that cycle, clear out_valid.
- overrun and frame_err clear only on reset.

## Timing
- Reset values: left_data = 0, right_data = 0, out_valid = 0, overrun = 0, frame_err = 0. The state is SYNC with bit_cnt = 0, lrc_q = 0, and both synchronizer flops at 0.
- adcdat to sample latency is 2 clk_50m cycles. The codec changes data at BCLK falling, so the synchronized bit is stable for more than 10 cycles before the next p_bclk at nominal rates.
- out_valid rises on the cycle after the p_bclk that captures the right-channel LSB. Data is stable from that same cycle until acceptance.
- left_data and right_data change only when a pair loads.
- Slot timing: a boundary plus DEPTH bits needs at least DEPTH+1 BCLK periods per slot. The timing generator supplies DEPTH+3, and surplus bits are ignored.
- Reset asserted mid-word or mid-handshake: on the next edge, all state returns to reset values and the partial word is lost. The block then resynchronizes at the next left boundary.

## Test plan
- Reset: hold rst_n = 0 for 4 cycles with random stimulus -> all outputs 0; out_valid stays 0 until the first full left/right frame.
- Normal frame: left = 16'hA5C3, right = 16'h1234, out_ready = 1 -> out_valid pulses for 1 cycle with left_data = A5C3, right_data = 1234; overrun = 0, frame_err = 0. Repeat over 8 random frames; every pair matches.
- Mid-frame start: release reset during a right slot carrying 16'hFFFF -> that word is never output; the first pair is the next full left/right frame.
- Backpressure: out_ready = 0 across 2 frames (pairs P1, P2) -> out_valid held with P1 data and overrun = 1 after P2 completes. Raise out_ready -> P1 accepted, P2 never appears, P3 is delivered normally.
- Short slot: toggle adc_lrc after 10 left bits -> frame_err = 1 and no pair for that frame; the following well-formed frame is output correctly.
- Simultaneous accept and complete: out_ready rises in the same cycle a new pair completes -> the new pair loads, out_valid stays 1, overrun stays 0.
